// File: rtl/mmio_console_timer.sv
// mmio_console_timer: memory-mapped console TX FIFO, status, free-running timer and compare/irq
module mmio_console_timer #(
  parameter logic [15:0] BASE = 16'hFF00,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [31:0] data_in,
  input  logic        write,
  output logic [31:0] data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] timer_q, timer_d, compare_q, compare_d, status;
  logic match_q, match_d, ovf_q, ovf_d;
  logic sel, empty, full, pop, push_req, push, wr_st;
  logic [7:0] off, head;
  always_comb begin
    sel = address[15:8] == BASE[15:8];
    off = address[7:0];
    empty = count_q == '0;
    full = count_q == CW'(FIFO_DEPTH);
    pop = !empty && tx_ready;
    push_req = sel && write && off == 8'd0;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    push = push_req && (!full || pop);
    wr_st = sel && write && off == 8'd1;
    head = empty ? 8'd0 : mem_q[rd_ptr_q];
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = data_in[7:0];
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    timer_d = (sel && write && off == 8'd2) ? data_in : timer_q + 32'd1;
    compare_d = (sel && write && off == 8'd3) ? data_in : compare_q;
    match_d = (timer_q == compare_q) || (match_q && !(wr_st && data_in[8]));
    ovf_d = (push_req && full && !pop) || (ovf_q && !(wr_st && data_in[9]));
    status = {22'd0, ovf_q, match_q, 2'd0, full, empty, 4'(count_q)};
    data_out = !sel ? 32'd0 :
               off == 8'd0 ? {24'd0, head} :
               off == 8'd1 ? status :
               off == 8'd2 ? timer_q :
               off == 8'd3 ? compare_q : 32'd0;
    tx_valid = !empty;
    tx_data = head;
    irq = match_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: 8'd0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      compare_q <= '1;
      match_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      timer_q <= timer_d;
      compare_q <= compare_d;
      match_q <= match_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mmio_console_timer.sv
// tb_mmio_console_timer: directed stimulus with queued expectations checked by a negedge monitor
module tb_mmio_console_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic write = 1'b0;
  logic tx_ready = 1'b0;
  logic [15:0] address = 16'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic [7:0] tx_data;
  logic tx_valid, irq;
  int total = 0;
  int bad = 0;
  typedef struct {string name; int kind; logic [31:0] exp;} item_t;
  item_t regq[$];
  logic [7:0] txq[$];
  logic hold_v = 1'b0;
  logic [7:0] hold_d = 8'd0;
  always #5 clk = ~clk;
  mmio_console_timer dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in), .write(write),
    .data_out(data_out), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // kind: 0 data_out, 1 tx_valid, 2 irq
  task automatic exp_q(input string n, input int k, input logic [31:0] e);
    regq.push_back('{n, k, e});
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string n);
    address = a;
    write = 1'b0;
    exp_q(n, 0, e);
    step();
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    write = 1'b1;
    step();
    write = 1'b0;
  endtask
  task automatic push_byte(input logic [7:0] b);
    txq.push_back(b);
    wr(16'hFF00, {24'd0, b});
  endtask
  task automatic drain(input string n);
    for (int i = 0; i < 20 && txq.size() > 0; i++) step();
    chk(n, txq.size(), 0);
  endtask
  always @(negedge clk) begin
    item_t e;
    logic [31:0] act;
    if (tx_valid && tx_ready) begin
      if (txq.size() == 0) chk("tx_extra", {24'd0, tx_data}, 32'hFFFFFFFF);
      else chk("tx_byte", {24'd0, tx_data}, {24'd0, txq.pop_front()});
    end
    if (hold_v && tx_valid) chk("tx_hold", {24'd0, tx_data}, {24'd0, hold_d});
    hold_v = tx_valid && !tx_ready;
    hold_d = tx_data;
    while (regq.size() > 0) begin
      e = regq.pop_front();
      act = e.kind == 0 ? data_out : e.kind == 1 ? {31'd0, tx_valid} : {31'd0, irq};
      chk(e.name, act, e.exp);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  initial begin
    step();
    exp_q("reset_valid", 1, 0);
    exp_q("reset_irq", 2, 0);
    rd(16'hFF03, 32'hFFFFFFFF, "reset_compare");
    reset = 1'b0;
    rd(16'hFF00, 32'h0, "rd_tx_empty");
    rd(16'hFF01, 32'h10, "status_reset");
    rd(16'hFF03, 32'hFFFFFFFF, "compare_reset");
    rd(16'hFF04, 32'h0, "rd_off4");
    rd(16'hFF80, 32'h0, "rd_off80");
    rd(16'h0000, 32'h0, "rd_unsel0");
    rd(16'h1234, 32'h0, "rd_unsel1234");
    for (int i = 0; i < 8; i++) push_byte(8'(8'h41 + i));
    wr(16'hFF00, 32'h49);
    rd(16'hFF01, 32'h228, "status_full_ovf");
    exp_q("valid_full", 1, 1);
    rd(16'hFF00, 32'h41, "rd_tx_head");
    tx_ready = 1'b1;
    drain("drain_seq");
    exp_q("valid_drained", 1, 0);
    rd(16'hFF01, 32'h210, "status_drained");
    wr(16'hFF01, 32'h200);
    rd(16'hFF01, 32'h10, "status_ovf_clr");
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
    tx_ready = 1'b1;
    push_byte(8'h5A);
    rd(16'hFF01, 32'h28, "status_full_pushpop");
    drain("drain_pushpop");
    rd(16'hFF01, 32'h10, "status_after_pushpop");
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h60 + i));
    for (int i = 0; i < 40; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      step();
    end
    tx_ready = 1'b1;
    drain("drain_random");
    wr(16'hFF02, 32'd100);
    wr(16'hFF03, 32'd105);
    for (int i = 101; i <= 105; i++) begin
      exp_q("irq_before_match", 2, 0);
      rd(16'hFF02, 32'(i), "timer_count");
    end
    exp_q("irq_match", 2, 1);
    rd(16'hFF01, 32'h110, "status_match");
    wr(16'hFF01, 32'h100);
    exp_q("irq_cleared", 2, 0);
    step();
    wr(16'hFF03, 32'd205);
    wr(16'hFF02, 32'd203);
    step();
    step();
    wr(16'hFF01, 32'h100);
    exp_q("irq_set_wins", 2, 1);
    step();
    wr(16'hFF01, 32'h100);
    exp_q("irq_cleared2", 2, 0);
    step();
    wr(16'hFF02, 32'hFFFFFFFE);
    rd(16'hFF02, 32'hFFFFFFFE, "timer_load");
    rd(16'hFF02, 32'hFFFFFFFF, "timer_max");
    rd(16'hFF02, 32'h0, "timer_wrap");
    tx_ready = 1'b0;
    address = 16'h1234;
    data_in = 32'hDEADBEEF;
    write = 1'b1;
    exp_q("unsel_write_rd", 0, 0);
    step();
    write = 1'b0;
    wr(16'hFF05, 32'h12345678);
    rd(16'hFF05, 32'h0, "rd_off5");
    rd(16'hFF03, 32'd205, "compare_kept");
    exp_q("valid_kept", 1, 0);
    rd(16'hFF01, 32'h10, "status_kept");
    for (int i = 0; i < 3; i++) push_byte(8'(8'h70 + i));
    exp_q("valid_three", 1, 1);
    rd(16'hFF01, 32'h3, "status_three");
    reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'd0, tx_valid}, 32'd0);
    chk("async_reset_status", data_out, 32'h10);
    txq.delete();
    step();
    reset = 1'b0;
    exp_q("irq_after_reset", 2, 0);
    rd(16'hFF01, 32'h10, "status_after_reset");
    rd(16'hFF03, 32'hFFFFFFFF, "compare_after_reset");
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
